// File: rtl/tdm_demux_8.sv
// Eight-channel TDM demultiplexer: aligns on sof, steers serial bits into an 8-bit frame word.
// Define TDM_DEMUX_PARITY_EN for a 9-slot frame with an even-parity check slot.
module tdm_demux_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d,
  input  logic       bit_valid,
  input  logic       sof,
  output logic [7:0] y,
  output logic       frame_valid,
  output logic [2:0] s,
  output logic       locked,
  output logic       sync_err,
  output logic       par_err
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t     state_r;
  logic [3:0] cnt_r;
  logic [7:0] sh_r;

  // Odd count of ones across the data and parity bit means the even-parity check failed.
  function automatic logic parity_fail(input logic [7:0] data, input logic pbit);
    return ^{data, pbit};
  endfunction

  // Frame alignment state machine; s always shadows the low bits of the next slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= HUNT;
      cnt_r       <= 4'd0;
      sh_r        <= 8'h00;
      y           <= 8'h00;
      frame_valid <= 1'b0;
      s           <= 3'd0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      par_err     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      par_err     <= 1'b0;
      if (bit_valid) begin
        case (state_r)
          HUNT: begin
            if (sof) begin
              sh_r[0] <= d;
              cnt_r   <= 4'd1;
              s       <= 3'd1;
              state_r <= LOCK;
              locked  <= 1'b1;
            end else begin
              cnt_r <= 4'd0;
              s     <= 3'd0;
            end
          end
          LOCK: begin
            if (cnt_r == 4'd0) begin
              if (sof) begin
                sh_r[0] <= d;
                cnt_r   <= 4'd1;
                s       <= 3'd1;
              end else begin
                // Slot 0 without a marker: alignment is lost, go back to hunting.
                sync_err <= 1'b1;
                state_r  <= HUNT;
                locked   <= 1'b0;
                cnt_r    <= 4'd0;
                s        <= 3'd0;
              end
            end else if (sof) begin
              // Early marker restarts the frame on this bit; the partial word is dropped.
              sync_err <= 1'b1;
              sh_r[0]  <= d;
              cnt_r    <= 4'd1;
              s        <= 3'd1;
            end else if (cnt_r == 4'd7) begin
`ifdef TDM_DEMUX_PARITY_EN
              sh_r[7] <= d;
              cnt_r   <= 4'd8;
              s       <= 3'd0;
`else
              y           <= {d, sh_r[6:0]};
              frame_valid <= 1'b1;
              cnt_r       <= 4'd0;
              s           <= 3'd0;
`endif
            end else if (cnt_r == 4'd8) begin
`ifdef TDM_DEMUX_PARITY_EN
              y           <= sh_r;
              frame_valid <= 1'b1;
              par_err     <= parity_fail(sh_r, d);
              cnt_r       <= 4'd0;
              s           <= 3'd0;
`else
              state_r <= HUNT;
              locked  <= 1'b0;
              cnt_r   <= 4'd0;
              s       <= 3'd0;
`endif
            end else begin
              sh_r[cnt_r[2:0]] <= d;
              cnt_r            <= cnt_r + 4'd1;
              s                <= cnt_r[2:0] + 3'd1;
            end
          end
          default: begin
            state_r <= HUNT;
            locked  <= 1'b0;
            cnt_r   <= 4'd0;
            s       <= 3'd0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule
